// File: rtl/exponent_diff.sv
// exponent_diff: exponent-compare stage of the floating-point add/sub path.
// It produces the following registered outputs:
//   - the absolute exponent difference,
//   - which operand has the larger exponent,
//   - a clamped alignment shift amount for the mantissa aligner.
// Optional build macro EXPDIFF_IN_REG_EN adds an input register stage,
// which makes the latency two cycles instead of one.
// Exponents are plain unsigned numbers here. The encodings 0 and all-ones
// are handled by the surrounding unit.
module exponent_diff #(
  parameter int EXP_W     = 8,
  parameter int SHIFT_MAX = 26,
  localparam int SHIFT_W  = $clog2(SHIFT_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [EXP_W-1:0]   expo1,
  input  logic [EXP_W-1:0]   expo2,
  output logic [EXP_W-1:0]   exp_diff,
  output logic               sel,
  output logic [SHIFT_W-1:0] shift_amt,
  output logic               shift_sat,
  output logic               exp_eq,
  output logic               out_valid
);

  localparam logic [EXP_W-1:0]   SHIFT_MAX_E = EXP_W'(SHIFT_MAX);
  localparam logic [SHIFT_W-1:0] SHIFT_MAX_S = SHIFT_W'(SHIFT_MAX);

  logic             w_valid;
  logic [EXP_W-1:0] w_expo1;
  logic [EXP_W-1:0] w_expo2;

`ifdef EXPDIFF_IN_REG_EN
  logic             r_in_valid;
  logic [EXP_W-1:0] r_expo1;
  logic [EXP_W-1:0] r_expo2;

  // Input register stage: capture operands and valid every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_valid <= 1'b0;
      r_expo1    <= '0;
      r_expo2    <= '0;
    end else begin
      r_in_valid <= in_valid;
      r_expo1    <= expo1;
      r_expo2    <= expo2;
    end
  end

  assign w_valid = r_in_valid;
  assign w_expo1 = r_expo1;
  assign w_expo2 = r_expo2;
`else
  assign w_valid = in_valid;
  assign w_expo1 = expo1;
  assign w_expo2 = expo2;
`endif

  logic [EXP_W:0]     w_sub;
  logic [EXP_W-1:0]   w_neg;
  logic               w_borrow;
  logic [EXP_W-1:0]   w_diff;
  logic               w_sat;
  logic [SHIFT_W-1:0] w_shift;

  // Extra MSB on the subtractor turns into the borrow, i.e. expo2 > expo1.
  // The difference is taken in whichever direction is non-negative.
  // Because of that it never wraps.
  always_comb begin
    w_sub    = {1'b0, w_expo1} - {1'b0, w_expo2};
    w_neg    = w_expo2 - w_expo1;
    w_borrow = w_sub[EXP_W];
    w_diff   = w_borrow ? w_neg : w_sub[EXP_W-1:0];
    w_sat    = (w_diff > SHIFT_MAX_E);
    w_shift  = w_sat ? SHIFT_MAX_S : w_diff[SHIFT_W-1:0];
  end

  // Output register stage.
  // Data is registered every cycle; only out_valid qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_diff  <= '0;
      sel       <= 1'b0;
      shift_amt <= '0;
      shift_sat <= 1'b0;
      exp_eq    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      exp_diff  <= w_diff;
      sel       <= w_borrow;
      shift_amt <= w_shift;
      shift_sat <= w_sat;
      exp_eq    <= (w_diff == '0);
      out_valid <= w_valid;
    end
  end

endmodule

// File: tb/tb_exponent_diff.sv
// Directed testbench for exponent_diff.
// The latency follows EXPDIFF_IN_REG_EN when that macro is defined.
module tb_exponent_diff;

`ifdef EXPDIFF_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] expo1;
  logic [7:0] expo2;
  logic [7:0] exp_diff;
  logic       sel;
  logic [4:0] shift_amt;
  logic       shift_sat;
  logic       exp_eq;
  logic       out_valid;

  int errors = 0;
  int checks = 0;

  exponent_diff dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .expo1     (expo1),
    .expo2     (expo2),
    .exp_diff  (exp_diff),
    .sel       (sel),
    .shift_amt (shift_amt),
    .shift_sat (shift_sat),
    .exp_eq    (exp_eq),
    .out_valid (out_valid)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Checks every output against hand-computed values.
  task automatic checkAll(input string tag, input int eDiff, input int eSel,
                          input int eShift, input int eSat, input int eEq,
                          input int eValid);
    checkOutput({tag, ".exp_diff"},  32'(exp_diff),  32'(eDiff));
    checkOutput({tag, ".sel"},       32'(sel),       32'(eSel));
    checkOutput({tag, ".shift_amt"}, 32'(shift_amt), 32'(eShift));
    checkOutput({tag, ".shift_sat"}, 32'(shift_sat), 32'(eSat));
    checkOutput({tag, ".exp_eq"},    32'(exp_eq),    32'(eEq));
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(eValid));
  endtask

  // Drives one operand pair on a falling edge.
  // It then waits out the pipeline latency and leaves the bench 1 ns after
  // the capturing edge.
  task automatic applyStimulus(input logic [7:0] e1, input logic [7:0] e2,
                               input logic v);
    @(negedge clk);
    expo1    = e1;
    expo2    = e2;
    in_valid = v;
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    expo1    = '0;
    expo2    = '0;
    #1;
    checkAll("reset0", 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'd5, 8'd11, 1'b1);
    checkAll("b_larger", 6, 1, 6, 0, 0, 1);

    applyStimulus(8'd30, 8'd10, 1'b1);
    checkAll("a_larger", 20, 0, 20, 0, 0, 1);

    applyStimulus(8'd5, 8'd15, 1'b1);
    checkAll("b_larger2", 10, 1, 10, 0, 0, 1);

    applyStimulus(8'd127, 8'd1, 1'b1);
    checkAll("sat_a", 126, 0, 26, 1, 0, 1);

    applyStimulus(8'd0, 8'd255, 1'b1);
    checkAll("sat_b_full", 255, 1, 26, 1, 0, 1);

    applyStimulus(8'd100, 8'd100, 1'b1);
    checkAll("equal", 0, 0, 0, 0, 1, 1);

    applyStimulus(8'd27, 8'd0, 1'b1);
    checkAll("edge27", 27, 0, 26, 1, 0, 1);

    applyStimulus(8'd0, 8'd26, 1'b1);
    checkAll("edge26", 26, 1, 26, 0, 0, 1);

    // Data still flows with in_valid low; only out_valid drops.
    applyStimulus(8'd40, 8'd43, 1'b0);
    checkAll("novalid", 3, 1, 3, 0, 0, 0);

    // Load a non-zero result, then pull reset between clock edges.
    applyStimulus(8'd255, 8'd0, 1'b1);
    checkAll("pre_reset", 255, 0, 26, 1, 0, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("async_reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    checkAll("held_reset", 0, 0, 0, 0, 0, 0);

    // Release reset and confirm the first result arrives after the latency.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'd5, 8'd11, 1'b1);
    checkAll("post_reset", 6, 1, 6, 0, 0, 1);

    applyStimulus(8'd9, 8'd2, 1'b0);
    checkAll("post_novalid", 7, 0, 7, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
